image_capture: RTL

IMAGE_CAPTURE -- requirements
Module: image_capture

---
 rtl/image_capture_pkg.sv | 20 ++
 rtl/image_capture.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/image_capture_pkg.sv
// Shared geometry, widths and FSM state type for the 32x32 drawing canvas capture block.
package image_capture_pkg;

    localparam int IMG_W    = 32;
    localparam int IMG_H    = 32;
    localparam int IMG_BITS = IMG_W * IMG_H;
    localparam int COORD_W  = 5;
    localparam int CNT_W    = 11;

    typedef enum logic [1:0] {
        ST_DRAW  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_SEND  = 2'd2
    } state_t;

    function automatic logic [IMG_W-1:0] bit_mask(input logic [COORD_W-1:0] x);
        return IMG_W'(1) << x;
    endfunction

endpackage

// File: rtl/image_capture.sv
// Canvas capture: pixel writes, row-by-row clear and a ready/valid frame hand-off downstream.
// Optional eraser support (per-write set/clear via wr_val) is enabled by IMAGE_CAPTURE_ERASER_EN.
module image_capture
    import image_capture_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic [COORD_W-1:0]  wr_x,
    input  logic [COORD_W-1:0]  wr_y,
    input  logic                wr_val,
    input  logic                clear,
    input  logic                submit,
    output logic                busy,
    output logic                img_valid,
    input  logic                img_ready,
    output logic [IMG_BITS-1:0] img_data,
    output logic [CNT_W-1:0]    pixel_count
);

    state_t               state_q, state_d;
    logic [IMG_W-1:0]     canvas_q [IMG_H];
    logic [IMG_W-1:0]     canvas_d [IMG_H];
    logic [COORD_W-1:0]   row_cnt_q, row_cnt_d;
    logic [CNT_W-1:0]     pixel_count_q, pixel_count_d;
    logic [IMG_BITS-1:0]  img_data_q, img_data_d;
    logic [IMG_BITS-1:0]  frame_now;

    logic draw_write;
    logic new_bit;
    logic old_bit;
    logic flip;
    logic last_row;

`ifdef IMAGE_CAPTURE_ERASER_EN
    assign new_bit = wr_val;
`else
    logic unused_wr_val;
    assign unused_wr_val = wr_val;
    assign new_bit       = 1'b1;
`endif

    // A write in the same cycle as clear is dropped; only real bit changes move the count.
    assign draw_write = (state_q == ST_DRAW) && wr_en && !clear;
    assign old_bit    = canvas_q[wr_y][wr_x];
    assign flip       = draw_write && (old_bit != new_bit);
    assign last_row   = (row_cnt_q == COORD_W'(IMG_H - 1));

    genvar gi;
    generate
        for (gi = 0; gi < IMG_H; gi++) begin : g_row
            logic clr_row;
            logic flip_row;
            assign clr_row  = (state_q == ST_CLEAR) && (row_cnt_q == COORD_W'(gi));
            assign flip_row = flip && (wr_y == COORD_W'(gi));
            assign canvas_d[gi] = clr_row  ? '0 :
                                  flip_row ? (canvas_q[gi] ^ bit_mask(wr_x)) :
                                             canvas_q[gi];
            // Frame snapshot sees any write landing on the same edge as submit.
            assign frame_now[gi*IMG_W +: IMG_W] = canvas_d[gi];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_DRAW;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_DRAW: begin
                if (clear) begin
                    state_d = ST_CLEAR;
                end else if (submit) begin
                    state_d = ST_SEND;
                end
            end
            ST_CLEAR: begin
                if (last_row) begin
                    state_d = ST_DRAW;
                end
            end
            ST_SEND: begin
                if (img_ready) begin
                    state_d = ST_DRAW;
                end
            end
            default: state_d = ST_DRAW;
        endcase
    end

    always_comb begin
        busy      = (state_q == ST_CLEAR) || (state_q == ST_SEND);
        img_valid = (state_q == ST_SEND);
    end

    always_comb begin
        row_cnt_d     = row_cnt_q;
        pixel_count_d = pixel_count_q;
        img_data_d    = img_data_q;
        case (state_q)
            ST_DRAW: begin
                if (clear) begin
                    row_cnt_d = '0;
                end else begin
                    if (flip) begin
                        pixel_count_d = new_bit ? (pixel_count_q + CNT_W'(1))
                                                : (pixel_count_q - CNT_W'(1));
                    end
                    if (submit) begin
                        img_data_d = frame_now;
                    end
                end
            end
            ST_CLEAR: begin
                row_cnt_d = row_cnt_q + COORD_W'(1);
                if (last_row) begin
                    pixel_count_d = '0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < IMG_H; r++) begin
                canvas_q[r] <= '0;
            end
            row_cnt_q     <= '0;
            pixel_count_q <= '0;
            img_data_q    <= '0;
        end else begin
            for (int r = 0; r < IMG_H; r++) begin
                canvas_q[r] <= canvas_d[r];
            end
            row_cnt_q     <= row_cnt_d;
            pixel_count_q <= pixel_count_d;
            img_data_q    <= img_data_d;
        end
    end

    assign img_data    = img_data_q;
    assign pixel_count = pixel_count_q;

endmodule
